pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB).
//  Detects load-use hazards and ID-resolved branches (beq/bne), and data-memory wait states.
//  Drives stall, bubble and flush controls to the PC and pipeline registers.
//  Its if2id_flush output feeds the control unit, which zeroes decoded controls while it is asserted.
// PARAMETERS
//  REG_AW       5     register address width
//  MEM_TIMEOUT  255   max MEMWAIT cycles before mem_err (>=1)
//  CNT_W        16    width of saturating stall-cycle counter
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       synchronous, active-high reset
//  id_ra_addr    in   REG_AW  source A of instr in ID
//  id_rb_addr    in   REG_AW  source B of instr in ID
//  id_ra_used    in   1       instr in ID reads A
//  id_rb_used    in   1       instr in ID reads B
//  id_br         in   2       00 none, 01 beq, 10 bne, 11 treated as none
//  id_br_eq      in   1       ID comparator: A==B
//  ex_memread    in   1       instr in EX is a load
//  ex_rd_addr    in   REG_AW  load destination in EX
//  mem_req       in   1       MEM stage accessing data memory this cycle
//  mem_ready     in   1       data memory completes access this cycle
//  pc_stall      out  1       hold PC
//  if2id_stall   out  1       hold IF/ID register
//  id2ex_bubble  out  1       load NOP into ID/EX
//  ex2mem_stall  out  1       hold ID/EX, EX/MEM; MEM/WB loads NOP
//  pc_sel_br     out  1       PC takes branch target next edge
//  if2id_flush   out  1       squash instr now in ID
//  mem_err       out  1       sticky: MEMWAIT exceeded MEM_TIMEOUT
//  stall_cnt     out  CNT_W   saturating count of cycles with pc_stall=1
// BEHAVIOUR
//  Reset: state=RUN, flush_q=0, wait_cnt=0, mem_err=0, stall_cnt=0.
//   All outputs 0 in the reset cycle and the cycle after.
//  Outputs are Mealy: decoded from registered state and current inputs, same cycle.
//  Hazard terms:
//   memhz = mem_req & ~mem_ready
//   ludhz = ex_memread & ex_rd_addr!=0 & ((id_ra_used & id_ra_addr==ex_rd_addr) | (id_rb_used & id_rb_addr==ex_rd_addr))
//   take  = (id_br==01 & id_br_eq) | (id_br==10 & ~id_br_eq)
//  Priority: memhz > ludhz > take.
//  FSM state RUN:
//   memhz: pc_stall, if2id_stall, ex2mem_stall = 1; id2ex_bubble=0; next MEMWAIT; wait_cnt<=1.
//   else ludhz: pc_stall, if2id_stall, id2ex_bubble = 1 for exactly this cycle; stay RUN.
//     Branch in ID is NOT evaluated; it is re-evaluated next cycle.
//   else take: pc_sel_br=1 this cycle; flush_q<=1.
//   if2id_flush = flush_q. flush_q clears on the first cycle it is seen with no freeze.
//  FSM state MEMWAIT:
//   Full freeze, same as the RUN memhz outputs; pc_sel_br=0; flush_q held.
//   mem_ready=1: exit to RUN next edge; this cycle's outputs are still frozen.
//   Otherwise wait_cnt++. When wait_cnt==MEM_TIMEOUT: mem_err<=1 (sticky), stay MEMWAIT.
//  FSM state ERR: none. mem_err never aborts the access; only rst clears it.
//  stall_cnt: +1 on every cycle with pc_stall=1; saturates at all-ones, no wrap.
//  Reset mid-MEMWAIT or with flush pending: returns to the reset state next edge; pending flush dropped.
//  Back-to-back branches: the flushed instr has zeroed id_br in the control unit, so it cannot take.
// STRUCTURE
//  pipe_defs.vh: state encodings RUN=1'b0, MEMWAIT=1'b1; id_br encodings BR_NONE/BR_EQ/BR_NE.
//   Opcode constants also live there, shared with the control unit.
//  One sub-module: sat_counter (param W, inc, clr) instantiated for stall_cnt.
//  wait_cnt stays inline.
// TESTING
//  1 Load r3 in EX, ID reads r3 (ra_used=1)
//     -> one cycle pc_stall=if2id_stall=id2ex_bubble=1, then 0; stall_cnt=1.
//  2 ex_rd_addr=0 matching id_ra_addr=0; also ra_used=0 match
//     -> no stall.
//  3 beq with id_br_eq=1
//     -> pc_sel_br=1 at cycle t, if2id_flush=1 at t+1 only.
//     bne with id_br_eq=1 -> neither asserted.
//  4 mem_req=1, mem_ready low 3 cycles then high
//     -> ex2mem_stall=1 for 4 cycles, RUN after; stall_cnt=4.
//     Taken branch at t, memhz at t+1 -> if2id_flush stays 1 through the freeze and clears after.
//  5 MEM_TIMEOUT=4, mem_ready held low
//     -> mem_err rises when wait_cnt hits 4 and stays high after mem_ready.
//     rst mid-wait -> all outputs 0 within 1 cycle.
//  6 CNT_W=4, 20 stall cycles
//     -> stall_cnt=15, no wrap.
//     ludhz and take in the same cycle -> bubble, no pc_sel_br; branch taken next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer and the control unit:
// FSM state encodings, branch-type encodings, opcodes and a branch-resolve helper.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;

    // Opcodes decoded by the control unit; kept here so both sides agree.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // Branch resolved in ID: beq taken on equal, bne taken on not-equal, 11 acts as none.
    function automatic logic br_taken(input logic [1:0] br, input logic eq);
        return ((br == BR_EQ) && eq) || ((br == BR_NE) && !eq);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc, hold at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, ID branch
// redirect/flush and data-memory wait freezes, plus a stall-cycle counter.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RUN     | normal issue; hazards decoded combinationally each cycle
//   MEMWAIT | data memory busy; whole pipe frozen until mem_ready
//
// Outputs are forced low during reset and the first cycle after it, so a
// stale pipeline picture right after reset cannot trigger a stall or redirect.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_ra_addr,
    input  logic [REG_AW-1:0] id_rb_addr,
    input  logic              id_ra_used,
    input  logic              id_rb_used,
    input  logic [1:0]        id_br,
    input  logic              id_br_eq,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd_addr,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_stall,
    output logic              if2id_stall,
    output logic              id2ex_bubble,
    output logic              ex2mem_stall,
    output logic              pc_sel_br,
    output logic              if2id_flush,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t            state;
    logic              flush_q;
    logic              rst_q;
    logic              err_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  cnt_q;

    logic live;
    logic memhz;
    logic ludhz;
    logic take;
    logic frozen;
    logic bubble;
    logic br_go;

    // Hazard decode; everything is masked while in or just out of reset.
    always_comb begin
        live   = !rst && !rst_q;
        memhz  = live && mem_req && !mem_ready;
        ludhz  = live && ex_memread && (ex_rd_addr != '0) &&
                 ((id_ra_used && (id_ra_addr == ex_rd_addr)) ||
                  (id_rb_used && (id_rb_addr == ex_rd_addr)));
        take   = live && br_taken(id_br, id_br_eq);
        frozen = live && ((state == MEMWAIT) || memhz);
        // A load-use stall defers the branch; it is re-resolved next cycle.
        bubble = !frozen && ludhz;
        br_go  = !frozen && !ludhz && take;
    end

    // Mealy control outputs from registered state and current hazards.
    always_comb begin
        pc_stall     = frozen || bubble;
        if2id_stall  = frozen || bubble;
        id2ex_bubble = bubble;
        ex2mem_stall = frozen;
        pc_sel_br    = br_go;
        if2id_flush  = live && flush_q;
        mem_err      = live && err_q;
        stall_cnt    = live ? cnt_q : '0;
    end

    // Sequencer FSM with pending-flush flag and memory wait timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            flush_q  <= 1'b0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            rst_q    <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            // The flush stays pending until the squashed instr is seen unfrozen.
            if (!frozen) begin
                flush_q <= br_go;
            end
            case (state)
                RUN: begin
                    if (memhz) begin
                        state    <= MEMWAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEMWAIT: begin
                    if (mem_ready) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_MAX) begin
                        // Flag the overrun but keep waiting; the access is never aborted.
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (pc_stall),
        .cnt (cnt_q)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each driven cycle pushes its
// expected outputs; a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

    localparam logic [1:0] BR_EQ = 2'b01;
    localparam logic [1:0] BR_NE = 2'b10;

    // {pc_stall, if2id_stall, id2ex_bubble, ex2mem_stall, pc_sel_br, if2id_flush, mem_err}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LUD  = 7'b1110000;
    localparam logic [6:0] C_FRZ  = 7'b1101000;
    localparam logic [6:0] C_BR   = 7'b0000100;
    localparam logic [6:0] C_FL   = 7'b0000010;
    localparam logic [6:0] C_ERR  = 7'b0000001;

    typedef struct packed {
        logic       rst;
        logic [4:0] ra;
        logic [4:0] rb;
        logic       ra_used;
        logic       rb_used;
        logic [1:0] br;
        logic       br_eq;
        logic       memread;
        logic [4:0] rd;
        logic       mem_req;
        logic       mem_ready;
    } vec_t;

    typedef struct {
        logic [6:0] ctl;
        int         cnt;
        int         idx;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [4:0] id_ra_addr;
    logic [4:0] id_rb_addr;
    logic       id_ra_used;
    logic       id_rb_used;
    logic [1:0] id_br;
    logic       id_br_eq;
    logic       ex_memread;
    logic [4:0] ex_rd_addr;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_stall;
    logic       if2id_stall;
    logic       id2ex_bubble;
    logic       ex2mem_stall;
    logic       pc_sel_br;
    logic       if2id_flush;
    logic       mem_err;
    logic [3:0] stall_cnt;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   step  = 0;
    vec_t I;
    vec_t v;

    pipe_hazard_ctrl #(
        .REG_AW(5),
        .MEM_TIMEOUT(4),
        .CNT_W(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_ra_addr   (id_ra_addr),
        .id_rb_addr   (id_rb_addr),
        .id_ra_used   (id_ra_used),
        .id_rb_used   (id_rb_used),
        .id_br        (id_br),
        .id_br_eq     (id_br_eq),
        .ex_memread   (ex_memread),
        .ex_rd_addr   (ex_rd_addr),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_stall     (pc_stall),
        .if2id_stall  (if2id_stall),
        .id2ex_bubble (id2ex_bubble),
        .ex2mem_stall (ex2mem_stall),
        .pc_sel_br    (pc_sel_br),
        .if2id_flush  (if2id_flush),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        rst        = x.rst;
        id_ra_addr = x.ra;
        id_rb_addr = x.rb;
        id_ra_used = x.ra_used;
        id_rb_used = x.rb_used;
        id_br      = x.br;
        id_br_eq   = x.br_eq;
        ex_memread = x.memread;
        ex_rd_addr = x.rd;
        mem_req    = x.mem_req;
        mem_ready  = x.mem_ready;
    endtask

    // Drive one cycle of stimulus and queue what the DUT must show during it.
    task automatic cyc(input vec_t x, input logic [6:0] ec, input int ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        apply(x);
        e.ctl = ec;
        e.cnt = ecnt;
        e.idx = step;
        sb.push_back(e);
        step++;
    endtask

    function automatic vec_t f_lud(input vec_t b);
        b.memread = 1'b1;
        b.rd      = 5'd3;
        b.ra      = 5'd3;
        b.ra_used = 1'b1;
        return b;
    endfunction

    function automatic vec_t f_br(input vec_t b, input logic [1:0] br, input logic eq);
        b.br    = br;
        b.br_eq = eq;
        return b;
    endfunction

    function automatic vec_t f_mem(input vec_t b, input logic rdy);
        b.mem_req   = 1'b1;
        b.mem_ready = rdy;
        return b;
    endfunction

    task automatic do_reset();
        vec_t r;
        r = f_lud(f_mem(I, 1'b0));
        r.rst = 1'b1;
        cyc(r, C_NONE, 0);
        cyc(f_lud(f_mem(I, 1'b0)), C_NONE, 0);
        cyc(I, C_NONE, 0);
    endtask

    // Compare DUT outputs mid-cycle against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_val($sformatf("s%0d ctl", e.idx),
                      {25'b0, pc_stall, if2id_stall, id2ex_bubble, ex2mem_stall,
                       pc_sel_br, if2id_flush, mem_err},
                      {25'b0, e.ctl});
            if (e.cnt >= 0) begin
                check_val($sformatf("s%0d stall_cnt", e.idx), {28'b0, stall_cnt}, e.cnt);
            end
        end
    end

    initial begin
        I = '0;
        apply(I);

        // load-use on A and on B, single-cycle bubble
        do_reset();
        cyc(f_lud(I), C_LUD, 0);
        cyc(I, C_NONE, 1);
        cyc(I, C_NONE, 1);
        v = I; v.memread = 1'b1; v.rd = 5'd7; v.ra = 5'd7; v.rb = 5'd7; v.rb_used = 1'b1;
        cyc(v, C_LUD, 1);
        cyc(I, C_NONE, 2);

        // non-hazards: r0 destination, unused source, not a load, different reg
        v = I; v.memread = 1'b1; v.rd = 5'd0; v.ra = 5'd0; v.ra_used = 1'b1;
        cyc(v, C_NONE, 2);
        v = I; v.memread = 1'b1; v.rd = 5'd5; v.ra = 5'd5; v.rb = 5'd5;
        cyc(v, C_NONE, 2);
        v = f_lud(I); v.memread = 1'b0;
        cyc(v, C_NONE, 2);
        v = f_lud(I); v.ra = 5'd4;
        cyc(v, C_NONE, 2);

        // branches
        cyc(f_br(I, BR_EQ, 1'b1), C_BR, 2);
        cyc(I, C_FL, 2);
        cyc(I, C_NONE, 2);
        cyc(f_br(I, BR_NE, 1'b1), C_NONE, 2);
        cyc(I, C_NONE, 2);
        cyc(f_br(I, BR_NE, 1'b0), C_BR, 2);
        cyc(I, C_FL, 2);
        cyc(f_br(I, 2'b11, 1'b1), C_NONE, 2);
        cyc(f_br(I, BR_EQ, 1'b0), C_NONE, 2);
        cyc(I, C_NONE, 2);

        // memory wait: 3 not-ready cycles then ready; hazards ignored while frozen
        do_reset();
        cyc(f_lud(f_mem(I, 1'b0)), C_FRZ, 0);
        cyc(f_mem(I, 1'b0), C_FRZ, 1);
        cyc(f_br(f_lud(f_mem(I, 1'b0)), BR_EQ, 1'b1), C_FRZ, 2);
        cyc(f_mem(I, 1'b1), C_FRZ, 3);
        cyc(I, C_NONE, 4);
        cyc(I, C_NONE, 4);
        // taken branch then freeze: flush held through the freeze
        cyc(f_br(I, BR_EQ, 1'b1), C_BR, 4);
        cyc(f_mem(I, 1'b0), C_FRZ | C_FL, 4);
        cyc(f_mem(I, 1'b1), C_FRZ | C_FL, 5);
        cyc(I, C_FL, 6);
        cyc(I, C_NONE, 6);

        // timeout with MEM_TIMEOUT=4
        do_reset();
        cyc(f_mem(I, 1'b0), C_FRZ, 0);
        cyc(f_mem(I, 1'b0), C_FRZ, 1);
        cyc(f_mem(I, 1'b0), C_FRZ, 2);
        cyc(f_mem(I, 1'b0), C_FRZ, 3);
        cyc(f_mem(I, 1'b0), C_FRZ, 4);
        cyc(f_mem(I, 1'b0), C_FRZ | C_ERR, 5);
        cyc(f_mem(I, 1'b1), C_FRZ | C_ERR, 6);
        cyc(I, C_ERR, 7);
        cyc(I, C_ERR, 7);
        // reset in the middle of a wait
        cyc(f_mem(I, 1'b0), C_FRZ | C_ERR, 7);
        cyc(f_mem(I, 1'b0), C_FRZ | C_ERR, 8);
        v = f_mem(I, 1'b0); v.rst = 1'b1;
        cyc(v, C_NONE, 0);
        cyc(f_mem(I, 1'b0), C_NONE, 0);
        cyc(f_mem(I, 1'b0), C_FRZ, 0);
        cyc(f_mem(I, 1'b1), C_FRZ, 1);
        cyc(I, C_NONE, 2);
        // reset with a flush pending drops it
        cyc(f_br(I, BR_EQ, 1'b1), C_BR, 2);
        v = I; v.rst = 1'b1;
        cyc(v, C_NONE, 0);
        cyc(I, C_NONE, 0);
        cyc(I, C_NONE, 0);

        // counter saturation at 15 with CNT_W=4
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(f_lud(I), C_LUD, (i > 15) ? 15 : i);
        end
        cyc(I, C_NONE, 15);
        cyc(I, C_NONE, 15);
        // load-use beats branch; branch taken the following cycle
        cyc(f_br(f_lud(I), BR_EQ, 1'b1), C_LUD, 15);
        cyc(f_br(I, BR_EQ, 1'b1), C_BR, 15);
        cyc(I, C_FL, 15);
        cyc(I, C_NONE, 15);

        @(negedge clk);
        #1;
        check_val("sb drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
